// File: rtl/pagerank_graph_loader_pkg.sv
// Shared constants and the loader FSM state type for the pagerank graph loader.
package pagerank_pkg;

  localparam logic [31:0] SENTINEL_ID = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD   = 3'd2,
    ENABLE = 3'd3,
    HOLD   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/pagerank_graph_loader_if.sv
// Edge-record stream into the loader.
// Handshake: a record transfers on a rising clock edge where edge_valid and edge_ready are both high;
// the master holds src/dst/last stable while valid is high, and edge_last marks the graph's final record.
interface pagerank_graph_loader_if;
  logic        edge_valid;
  logic        edge_ready;
  logic [31:0] edge_src;
  logic [31:0] edge_dst;
  logic        edge_last;

  modport master (output edge_valid, edge_src, edge_dst, edge_last, input edge_ready);
  modport slave  (input edge_valid, edge_src, edge_dst, edge_last, output edge_ready);
endinterface

// File: rtl/pagerank_graph_loader_bank.sv
// One partition's adjacency storage: per-slot out-degree counter and destination list.
module pagerank_graph_bank
  import pagerank_pkg::*;
#(
  parameter int NODES  = 4,
  parameter int STREAM = 20,
  localparam int SLOT_W = (NODES > 1) ? $clog2(NODES) : 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                clear_i,
  input  logic                                wr_en_i,
  input  logic [SLOT_W-1:0]                   slot_i,
  input  logic [31:0]                         dst_i,
  output logic [NODES-1:0][31:0]              degree_o,
  output logic [NODES-1:0][STREAM-1:0][31:0]  dest_o,
  output logic [NODES-1:0]                    full_o
);

  localparam int DEG_W = $clog2(STREAM + 1);
  localparam int IDX_W = (STREAM > 1) ? $clog2(STREAM) : 1;

  logic [NODES-1:0][DEG_W-1:0]        deg_q, deg_d;
  logic [NODES-1:0][STREAM-1:0][31:0] dest_q, dest_d;

  // A full slot silently drops the write; the loader raises the overflow flag.
  always_comb begin
    deg_d  = deg_q;
    dest_d = dest_q;
    if (clear_i) begin
      deg_d  = '0;
      dest_d = {NODES*STREAM{SENTINEL_ID}};
    end else if (wr_en_i && !full_o[slot_i]) begin
      dest_d[slot_i][IDX_W'(deg_q[slot_i])] = dst_i;
      deg_d[slot_i] = deg_q[slot_i] + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      deg_q  <= '0;
      dest_q <= {NODES*STREAM{SENTINEL_ID}};
    end else begin
      deg_q  <= deg_d;
      dest_q <= dest_d;
    end
  end

  for (genvar k = 0; k < NODES; k++) begin : g_slot
    assign full_o[k]   = (deg_q[k] == DEG_W'(STREAM));
    assign degree_o[k] = 32'(deg_q[k]);
  end

  assign dest_o = dest_q;

endmodule

// File: rtl/pagerank_graph_loader.sv
// Builds per-partition adjacency arrays from a serial (src,dst) edge stream and pulses pagerank_enable when done.
module pagerank_graph_loader
  import pagerank_pkg::*;
#(
  parameter int NUM_HW_THREADS     = 8,
  parameter int NODES_IN_PARTITION = 4,
  parameter int NODES_IN_GRAPH     = 32,
  parameter int STREAM_SIZE        = 20
) (
  input  logic                                                               clock,
  input  logic                                                               reset_n,
  input  logic                                                               load_start,
  pagerank_graph_loader_if.slave                                             edge_bus,
  output logic [NUM_HW_THREADS-1:0][NODES_IN_PARTITION-1:0][31:0]            source_id,
  output logic [NUM_HW_THREADS-1:0][NODES_IN_PARTITION-1:0][31:0]            out_degree,
  output logic [NUM_HW_THREADS-1:0][NODES_IN_PARTITION-1:0][STREAM_SIZE-1:0][31:0] dest_id,
  output logic                                                               pagerank_enable,
  output logic                                                               load_done,
  output logic                                                               range_error,
  output logic                                                               degree_overflow,
  output loader_state_t                                                      dbg_state
);

  localparam int SLOT_W = (NODES_IN_PARTITION > 1) ? $clog2(NODES_IN_PARTITION) : 1;
  localparam int PART_W = (NUM_HW_THREADS > 1) ? $clog2(NUM_HW_THREADS) : 1;

  if (NODES_IN_GRAPH != NUM_HW_THREADS * NODES_IN_PARTITION) begin : g_bad_params
    $error("NODES_IN_GRAPH must equal NUM_HW_THREADS*NODES_IN_PARTITION");
  end

  loader_state_t state_q, state_d;
  logic          accept, in_range, target_full, clear_banks;
  logic [31:0]   part_idx;
  logic [PART_W-1:0] part_sel;
  logic [SLOT_W-1:0] slot_sel;
  logic [NUM_HW_THREADS-1:0]                         wr_en;
  logic [NUM_HW_THREADS-1:0][NODES_IN_PARTITION-1:0] full_w;
  logic          range_error_q, range_error_d;
  logic          overflow_q, overflow_d;

  assign accept    = edge_bus.edge_valid & edge_bus.edge_ready;
  assign in_range  = (edge_bus.edge_src < 32'(NODES_IN_GRAPH)) && (edge_bus.edge_dst < 32'(NODES_IN_GRAPH));
  assign part_idx  = edge_bus.edge_src / 32'(NODES_IN_PARTITION);
  assign slot_sel  = SLOT_W'(edge_bus.edge_src % 32'(NODES_IN_PARTITION));
  assign part_sel  = PART_W'(part_idx);
  assign target_full = full_w[part_sel][slot_sel];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (load_start) state_d = CLEAR;
      CLEAR:   state_d = LOAD;
      LOAD:    if (accept && edge_bus.edge_last) state_d = ENABLE;
      ENABLE:  state_d = HOLD;
      HOLD:    if (load_start) state_d = CLEAR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    edge_bus.edge_ready = (state_q == LOAD);
    pagerank_enable     = (state_q == ENABLE);
    load_done           = (state_q == HOLD);
    clear_banks         = (state_q == CLEAR);
  end

  // Out-of-range edges are rejected before the saturation check so they never touch a bank.
  always_comb begin
    range_error_d = range_error_q;
    overflow_d    = overflow_q;
    if (clear_banks) begin
      range_error_d = 1'b0;
      overflow_d    = 1'b0;
    end else if (accept) begin
      if (!in_range)        range_error_d = 1'b1;
      else if (target_full) overflow_d    = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      range_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      range_error_q <= range_error_d;
      overflow_q    <= overflow_d;
    end
  end

  assign range_error     = range_error_q;
  assign degree_overflow = overflow_q;
  assign dbg_state       = state_q;

  for (genvar g = 0; g < NUM_HW_THREADS; g++) begin : g_part
    assign wr_en[g] = accept & in_range & (part_idx == 32'(g));

    pagerank_graph_bank #(
      .NODES  (NODES_IN_PARTITION),
      .STREAM (STREAM_SIZE)
    ) u_bank (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear_i  (clear_banks),
      .wr_en_i  (wr_en[g]),
      .slot_i   (slot_sel),
      .dst_i    (edge_bus.edge_dst),
      .degree_o (out_degree[g]),
      .dest_o   (dest_id[g]),
      .full_o   (full_w[g])
    );

    for (genvar k = 0; k < NODES_IN_PARTITION; k++) begin : g_src
      assign source_id[g][k] = 32'(g * NODES_IN_PARTITION + k);
    end
  end

endmodule
